// File: rtl/vga_pipe_ctrl.sv
// vga_pipe_ctrl: VGA raster timing with pipeline-aligned sync and colour,
// per-pixel darkening and a frame-paced global fade toward a brightness goal.
module vga_pipe_ctrl #(
   parameter int HD          = 640,
   parameter int HF          = 16,
   parameter int HS          = 96,
   parameter int HB          = 48,
   parameter int VD          = 480,
   parameter int VF          = 10,
   parameter int VS          = 2,
   parameter int VB          = 33,
   parameter int CW          = 10,
   parameter int PIPE        = 2,
   parameter int FADE_FRAMES = 2,
   parameter bit SYNC_POL    = 1'b0
) (
   input  logic          div_2,
   input  logic          rst,
   input  logic [11:0]   pixel_in,
   input  logic [3:0]    dim,
   input  logic [3:0]    fade_target,
   output logic [CW-1:0] h_cnt,
   output logic [CW-1:0] v_cnt,
   output logic          frame_start,
   output logic [3:0]    fade_level,
   output logic          fade_done,
   output logic          hsync,
   output logic          vsync,
   output logic [3:0]    vgaRed,
   output logic [3:0]    vgaGreen,
   output logic [3:0]    vgaBlue
);

   localparam int HT   = HD + HF + HS + HB;
   localparam int VT   = VD + VF + VS + VB;
   localparam int FC_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

   localparam logic [CW-1:0]   ONE    = CW'(1);
   localparam logic [CW-1:0]   H_LAST = CW'(HT - 1);
   localparam logic [CW-1:0]   V_LAST = CW'(VT - 1);
   localparam logic [CW-1:0]   H_ACT  = CW'(HD);
   localparam logic [CW-1:0]   V_ACT  = CW'(VD);
   localparam logic [CW-1:0]   HS_BEG = CW'(HD + HF);
   localparam logic [CW-1:0]   HS_END = CW'(HD + HF + HS - 1);
   localparam logic [CW-1:0]   VS_BEG = CW'(VD + VF);
   localparam logic [CW-1:0]   VS_END = CW'(VD + VF + VS - 1);
   localparam logic [FC_W-1:0] F_LAST = FC_W'(FADE_FRAMES - 1);
   localparam logic [FC_W-1:0] F_ONE  = FC_W'(1);

   logic [CW-1:0]   pixel_cnt;
   logic [CW-1:0]   line_cnt;
   logic [FC_W-1:0] fcnt;
   logic            raw_h;
   logic            raw_v;
   logic            raw_valid;
   logic [PIPE-1:0] h_pipe;
   logic [PIPE-1:0] v_pipe;
   logic [PIPE-1:0] valid_pipe;
   logic [11:0]     pix_r;
   logic [3:0]      dim_r;
   logic [4:0]      k_sum;
   logic [3:0]      k_amt;

   // Darken one channel by k, clamping at zero.
   function automatic logic [3:0] shade(input logic [3:0] c, input logic [3:0] k);
      return (c > k) ? (c - k) : 4'd0;
   endfunction

   // Raster position: pixel wraps each line, line advances at end of line and wraps each frame.
   always_ff @(posedge div_2 or negedge rst) begin
      if (!rst) begin
         pixel_cnt <= '0;
         line_cnt  <= '0;
      end else if (pixel_cnt == H_LAST) begin
         pixel_cnt <= '0;
         if (line_cnt == V_LAST) begin
            line_cnt <= '0;
         end else begin
            line_cnt <= line_cnt + ONE;
         end
      end else begin
         pixel_cnt <= pixel_cnt + ONE;
      end
   end

   // Undelayed decode of the raster position: visible counters, frame marker, raw sync/valid.
   always_comb begin
      raw_h       = (pixel_cnt >= HS_BEG) && (pixel_cnt <= HS_END);
      raw_v       = (line_cnt >= VS_BEG) && (line_cnt <= VS_END);
      raw_valid   = (pixel_cnt < H_ACT) && (line_cnt < V_ACT);
      h_cnt       = (pixel_cnt < H_ACT) ? pixel_cnt : '0;
      v_cnt       = (line_cnt < V_ACT) ? line_cnt : '0;
      frame_start = (pixel_cnt == '0) && (line_cnt == '0);
   end

   // Delay sync and valid by PIPE stages; pixel data joins at the last stage so all leave together.
   always_ff @(posedge div_2 or negedge rst) begin
      if (!rst) begin
         h_pipe     <= '0;
         v_pipe     <= '0;
         valid_pipe <= '0;
         pix_r      <= 12'h000;
         dim_r      <= 4'h0;
      end else begin
         h_pipe[0]     <= raw_h;
         v_pipe[0]     <= raw_v;
         valid_pipe[0] <= raw_valid;
         for (int i = 1; i < PIPE; i++) begin
            h_pipe[i]     <= h_pipe[i-1];
            v_pipe[i]     <= v_pipe[i-1];
            valid_pipe[i] <= valid_pipe[i-1];
         end
         pix_r <= pixel_in;
         dim_r <= dim;
      end
   end

   // Frame pacing and fade: every FADE_FRAMES-th frame start moves the level one step toward the goal.
   always_ff @(posedge div_2 or negedge rst) begin
      if (!rst) begin
         fcnt       <= '0;
         fade_level <= 4'd15;
      end else if (frame_start) begin
         if (fcnt == F_LAST) begin
            fcnt <= '0;
            if (fade_level < fade_target) begin
               fade_level <= fade_level + 4'd1;
            end else if (fade_level > fade_target) begin
               fade_level <= fade_level - 4'd1;
            end else begin
               fade_level <= fade_level;
            end
         end else begin
            fcnt <= fcnt + F_ONE;
         end
      end else begin
         fcnt <= fcnt;
      end
   end

   // Output drive: sync polarity, fade status and darkened colour from the final-stage registers.
   always_comb begin
      hsync     = h_pipe[PIPE-1] ? SYNC_POL : ~SYNC_POL;
      vsync     = v_pipe[PIPE-1] ? SYNC_POL : ~SYNC_POL;
      fade_done = (fade_level == fade_target);
      k_sum     = {1'b0, fade_level} + {1'b0, dim_r};
      k_amt     = (k_sum > 5'd15) ? 4'd15 : k_sum[3:0];
      if (valid_pipe[PIPE-1]) begin
         vgaRed   = shade(pix_r[11:8], k_amt);
         vgaGreen = shade(pix_r[7:4], k_amt);
         vgaBlue  = shade(pix_r[3:0], k_amt);
      end else begin
         vgaRed   = 4'd0;
         vgaGreen = 4'd0;
         vgaBlue  = 4'd0;
      end
   end

endmodule

// File: tb/tb_vga_pipe_ctrl.sv
// tb_vga_pipe_ctrl: randomized stimulus against an arithmetic raster/fade model,
// two instances (PIPE=2 and PIPE=4) on a reduced raster.
module tb_vga_pipe_ctrl;

   localparam int HD = 16, HF = 2, HS = 3, HB = 3;
   localparam int VD = 8, VF = 1, VS = 2, VB = 2;
   localparam int FF = 2;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        div_2 = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] pixel_in = 12'h000;
   logic [3:0]  dim = 4'h0;
   logic [3:0]  fade_target = 4'h0;

   logic [9:0] h_cnt_a, v_cnt_a, h_cnt_b, v_cnt_b;
   logic       fs_a, fd_a, hs_a, vs_a, fs_b, fd_b, hs_b, vs_b;
   logic [3:0] fl_a, r_a, g_a, b_a, fl_b, r_b, g_b, b_b;

   int n_chk = 0;
   int n_fail = 0;

   // model state
   int          t = 0;
   int          lvl = 15;
   logic [11:0] cur_pix = 12'h000, last_pix = 12'h000;
   logic [3:0]  cur_dim = 4'h0, last_dim = 4'h0, cur_ft = 4'h0;

   vga_pipe_ctrl #(.HD(HD), .HF(HF), .HS(HS), .HB(HB), .VD(VD), .VF(VF), .VS(VS), .VB(VB),
                   .CW(10), .PIPE(2), .FADE_FRAMES(FF), .SYNC_POL(1'b0)) u_dut_a (
      .div_2(div_2), .rst(rst), .pixel_in(pixel_in), .dim(dim), .fade_target(fade_target),
      .h_cnt(h_cnt_a), .v_cnt(v_cnt_a), .frame_start(fs_a), .fade_level(fl_a), .fade_done(fd_a),
      .hsync(hs_a), .vsync(vs_a), .vgaRed(r_a), .vgaGreen(g_a), .vgaBlue(b_a));

   vga_pipe_ctrl #(.HD(HD), .HF(HF), .HS(HS), .HB(HB), .VD(VD), .VF(VF), .VS(VS), .VB(VB),
                   .CW(10), .PIPE(4), .FADE_FRAMES(FF), .SYNC_POL(1'b0)) u_dut_b (
      .div_2(div_2), .rst(rst), .pixel_in(pixel_in), .dim(dim), .fade_target(fade_target),
      .h_cnt(h_cnt_b), .v_cnt(v_cnt_b), .frame_start(fs_b), .fade_level(fl_b), .fade_done(fd_b),
      .hsync(hs_b), .vsync(vs_b), .vgaRed(r_b), .vgaGreen(g_b), .vgaBlue(b_b));

   always #5 div_2 = ~div_2;

   // visible pixel at cycle tt seen through a p-cycle pipeline
   function automatic bit vld(int tt, int p);
      int s;
      if (tt < p) return 1'b0;
      s = tt - p;
      return ((s % HT) < HD) && (((s / HT) % VT) < VD);
   endfunction

   function automatic logic [1:0] exp_sync(int p);
      int s, pc, lc;
      bit h, v;
      if (t < p) return 2'b11;
      s  = t - p;
      pc = s % HT;
      lc = (s / HT) % VT;
      h  = (pc >= HD + HF) && (pc < HD + HF + HS);
      v  = (lc >= VD + VF) && (lc < VD + VF + VS);
      return {~h, ~v};
   endfunction

   function automatic logic [11:0] exp_rgb(int p);
      int k, c;
      logic [11:0] r;
      r = 12'h000;
      if (!vld(t, p)) return r;
      k = lvl + int'(last_dim);
      if (k > 15) k = 15;
      for (int ch = 0; ch < 3; ch++) begin
         c = int'(last_pix[ch*4 +: 4]);
         r[ch*4 +: 4] = (c > k) ? 4'(c - k) : 4'h0;
      end
      return r;
   endfunction

   function automatic logic [20:0] exp_cnt();
      int pc, lc;
      pc = t % HT;
      lc = (t / HT) % VT;
      return {(pc < HD) ? 10'(pc) : 10'd0, (lc < VD) ? 10'(lc) : 10'd0, (pc == 0 && lc == 0)};
   endfunction

   task automatic drive(input logic [11:0] p, input logic [3:0] d, input logic [3:0] ft);
      pixel_in = p; dim = d; fade_target = ft;
      cur_pix = p; cur_dim = d; cur_ft = ft;
   endtask

   // advance one clock and the model with it (fade step on every FF-th frame start)
   task automatic tick();
      @(posedge div_2);
      if ((t % FT) == 0 && ((t / FT) % FF) == FF - 1) begin
         if (lvl < int'(cur_ft)) lvl++;
         else if (lvl > int'(cur_ft)) lvl--;
      end
      last_pix = cur_pix;
      last_dim = cur_dim;
      t++;
      #1;
   endtask

   task automatic apply_reset();
      @(posedge div_2); #1;
      rst = 1'b0;
      @(posedge div_2); #1;
      rst = 1'b1;
      t = 0;
      lvl = 15;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(12'h5A5, 4'h2, 4'h0);
      repeat (2) @(posedge div_2);
      @(negedge div_2);
      n_chk++; if ({h_cnt_a, v_cnt_a, fs_a, h_cnt_b, v_cnt_b, fs_b} !== {10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b1}) begin
         n_fail++; $display("FAIL reset_cnt got %h %h %b", h_cnt_a, v_cnt_a, fs_a); end
      n_chk++; if ({fl_a, fd_a, fl_b, fd_b} !== {4'hF, 1'b0, 4'hF, 1'b0}) begin
         n_fail++; $display("FAIL reset_fade got %h/%b %h/%b want f/0", fl_a, fd_a, fl_b, fd_b); end
      n_chk++; if ({hs_a, vs_a, hs_b, vs_b} !== 4'b1111) begin
         n_fail++; $display("FAIL reset_sync got %b%b%b%b want 1111", hs_a, vs_a, hs_b, vs_b); end
      n_chk++; if ({r_a, g_a, b_a, r_b, g_b, b_b} !== 24'h000000) begin
         n_fail++; $display("FAIL reset_rgb got %h%h%h %h%h%h want 0", r_a, g_a, b_a, r_b, g_b, b_b); end
      @(posedge div_2); #1;
      rst = 1'b1;
      t = 0;
      lvl = 15;
   endtask

   // full per-cycle check of counters, sync, fade and colour with a random fade goal
   task automatic test_timing();
      logic [3:0] ft;
      ft = 4'($urandom_range(0, 15));
      for (int i = 0; i < FT + 40; i++) begin
         drive(12'($urandom), 4'($urandom), ft);
         @(negedge div_2);
         n_chk++; if ({h_cnt_a, v_cnt_a, fs_a} !== exp_cnt()) begin
            n_fail++; $display("FAIL tim_cnt_a t=%0d got %h want %h", t, {h_cnt_a, v_cnt_a, fs_a}, exp_cnt()); end
         n_chk++; if ({h_cnt_b, v_cnt_b, fs_b} !== exp_cnt()) begin
            n_fail++; $display("FAIL tim_cnt_b t=%0d got %h want %h", t, {h_cnt_b, v_cnt_b, fs_b}, exp_cnt()); end
         n_chk++; if ({hs_a, vs_a} !== exp_sync(2)) begin
            n_fail++; $display("FAIL tim_sync_a t=%0d got %b%b want %b", t, hs_a, vs_a, exp_sync(2)); end
         n_chk++; if ({hs_b, vs_b} !== exp_sync(4)) begin
            n_fail++; $display("FAIL tim_sync_b t=%0d got %b%b want %b", t, hs_b, vs_b, exp_sync(4)); end
         n_chk++; if ({fl_a, fd_a} !== {4'(lvl), lvl == int'(ft)}) begin
            n_fail++; $display("FAIL tim_fade t=%0d got %h/%b want %0d", t, fl_a, fd_a, lvl); end
         n_chk++; if ({r_a, g_a, b_a} !== exp_rgb(2)) begin
            n_fail++; $display("FAIL tim_rgb_a t=%0d got %h%h%h want %h", t, r_a, g_a, b_a, exp_rgb(2)); end
         n_chk++; if ({r_b, g_b, b_b} !== exp_rgb(4)) begin
            n_fail++; $display("FAIL tim_rgb_b t=%0d got %h%h%h want %h", t, r_b, g_b, b_b, exp_rgb(4)); end
         tick();
      end
   endtask

   // head toward 0, retarget to 12 when the level reaches 8
   task automatic test_fade_reverse();
      bit switched = 1'b0, seen9 = 1'b0, done = 1'b0;
      int tgt = 0;
      apply_reset();
      for (int i = 0; i < 40 * FT && !done; i++) begin
         if (!switched && lvl == 8) begin switched = 1'b1; tgt = 12; end
         drive(12'($urandom), 4'($urandom), 4'(tgt));
         @(negedge div_2);
         n_chk++; if ({fl_a, fd_a, fl_b, fd_b} !== {4'(lvl), lvl == tgt, 4'(lvl), lvl == tgt}) begin
            n_fail++; $display("FAIL rev_fade t=%0d got %h/%b %h/%b want %0d", t, fl_a, fd_a, fl_b, fd_b, lvl); end
         if (switched && !seen9 && lvl != 8) begin
            seen9 = 1'b1;
            n_chk++; if (fl_a !== 4'd9) begin
               n_fail++; $display("FAIL rev_first_step got %0d want 9", fl_a); end
         end
         if (lvl == 12 && t >= 23 * FT) done = 1'b1;
         tick();
      end
      n_chk++; if (!done) begin
         n_fail++; $display("FAIL rev_timeout got level %0d want 12", fl_a); end
      n_chk++; if ({fl_a, fd_a} !== {4'd12, 1'b1}) begin
         n_fail++; $display("FAIL rev_final got %h/%b want c/1", fl_a, fd_a); end
   endtask

   // fade from 15 to 0 with goal 0 from reset
   task automatic test_fade_to_zero();
      apply_reset();
      for (int i = 0; i < 30 * FT + 3; i++) begin
         drive(12'($urandom), 4'($urandom), 4'h0);
         @(negedge div_2);
         n_chk++; if ({fl_a, fd_a, fl_b, fd_b} !== {4'(lvl), lvl == 0, 4'(lvl), lvl == 0}) begin
            n_fail++; $display("FAIL zero_fade t=%0d got %h/%b %h/%b want %0d", t, fl_a, fd_a, fl_b, fd_b, lvl); end
         if (t == FT) begin
            n_chk++; if (fl_a !== 4'd15) begin n_fail++; $display("FAIL zero_f1_pre got %0d want 15", fl_a); end
         end
         if (t == FT + 1) begin
            n_chk++; if (fl_a !== 4'd14) begin n_fail++; $display("FAIL zero_f1 got %0d want 14", fl_a); end
         end
         if (t == 29 * FT) begin
            n_chk++; if ({fl_a, fd_a} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL zero_f29_pre got %h/%b want 1/0", fl_a, fd_a); end
         end
         if (t == 29 * FT + 1) begin
            n_chk++; if ({fl_a, fd_a} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL zero_f29 got %h/%b want 0/1", fl_a, fd_a); end
         end
         tick();
      end
   endtask

   // colour path at fade level 0: random data, fixed ABC cases, full-white window
   task automatic test_colour();
      int cnt_a = 0, cnt_b = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         drive(12'($urandom), 4'($urandom), 4'h0);
         @(negedge div_2);
         n_chk++; if ({r_a, g_a, b_a} !== exp_rgb(2)) begin
            n_fail++; $display("FAIL col_rand_a t=%0d got %h%h%h want %h", t, r_a, g_a, b_a, exp_rgb(2)); end
         n_chk++; if ({r_b, g_b, b_b} !== exp_rgb(4)) begin
            n_fail++; $display("FAIL col_rand_b t=%0d got %h%h%h want %h", t, r_b, g_b, b_b, exp_rgb(4)); end
         tick();
      end
      drive(12'hABC, 4'd3, 4'h0);
      tick();
      for (int i = 0; i < FT; i++) begin
         @(negedge div_2);
         n_chk++; if ({r_a, g_a, b_a} !== (vld(t, 2) ? 12'h789 : 12'h000)) begin
            n_fail++; $display("FAIL col_abc_d3 t=%0d got %h%h%h want 789 in window", t, r_a, g_a, b_a); end
         tick();
      end
      drive(12'hABC, 4'd14, 4'h0);
      tick();
      for (int i = 0; i < FT / 2; i++) begin
         @(negedge div_2);
         n_chk++; if ({r_a, g_a, b_a, r_b, g_b, b_b} !== 24'h000000) begin
            n_fail++; $display("FAIL col_abc_d14 t=%0d got %h%h%h want 000", t, r_a, g_a, b_a); end
         tick();
      end
      drive(12'hFFF, 4'd0, 4'h0);
      tick();
      for (int i = 0; i < FT; i++) begin
         @(negedge div_2);
         n_chk++; if ({r_a, g_a, b_a} !== (vld(t, 2) ? 12'hFFF : 12'h000)) begin
            n_fail++; $display("FAIL col_white_a t=%0d got %h%h%h", t, r_a, g_a, b_a); end
         n_chk++; if ({r_b, g_b, b_b} !== (vld(t, 4) ? 12'hFFF : 12'h000)) begin
            n_fail++; $display("FAIL col_white_b t=%0d got %h%h%h", t, r_b, g_b, b_b); end
         if ({r_a, g_a, b_a} === 12'hFFF) cnt_a++;
         if ({r_b, g_b, b_b} === 12'hFFF) cnt_b++;
         tick();
      end
      n_chk++; if (cnt_a != HD * VD || cnt_b != HD * VD) begin
         n_fail++; $display("FAIL col_white_count got %0d/%0d want %0d", cnt_a, cnt_b, HD * VD); end
   endtask

   // reset in the middle of a frame, then the raster must restart from the origin
   task automatic test_mid_reset();
      for (int i = 0; i < FT + 100; i++) begin
         drive(12'($urandom), 4'($urandom), 4'h3);
         tick();
      end
      rst = 1'b0;
      @(negedge div_2);
      n_chk++; if ({h_cnt_a, v_cnt_a, fs_a, fl_a, hs_a, vs_a, hs_b, vs_b} !== {10'd0, 10'd0, 1'b1, 4'hF, 4'b1111}) begin
         n_fail++; $display("FAIL mid_reset_state got %h %h %b %h %b%b", h_cnt_a, v_cnt_a, fs_a, fl_a, hs_a, vs_a); end
      n_chk++; if ({r_a, g_a, b_a, r_b, g_b, b_b} !== 24'h000000) begin
         n_fail++; $display("FAIL mid_reset_rgb got %h%h%h want 000", r_a, g_a, b_a); end
      @(posedge div_2); #1;
      rst = 1'b1;
      t = 0;
      lvl = 15;
      for (int i = 0; i < FT + 30; i++) begin
         drive(12'($urandom), 4'($urandom), 4'h3);
         @(negedge div_2);
         n_chk++; if ({h_cnt_a, v_cnt_a, fs_a} !== exp_cnt()) begin
            n_fail++; $display("FAIL mid_cnt t=%0d got %h want %h", t, {h_cnt_a, v_cnt_a, fs_a}, exp_cnt()); end
         n_chk++; if ({hs_a, vs_a, hs_b, vs_b} !== {exp_sync(2), exp_sync(4)}) begin
            n_fail++; $display("FAIL mid_sync t=%0d got %b%b%b%b", t, hs_a, vs_a, hs_b, vs_b); end
         n_chk++; if ({fl_a, r_a, g_a, b_a} !== {4'(lvl), exp_rgb(2)}) begin
            n_fail++; $display("FAIL mid_out t=%0d got %h %h%h%h want %0d %h", t, fl_a, r_a, g_a, b_a, lvl, exp_rgb(2)); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_fade_reverse();
      test_fade_to_zero();
      test_colour();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
